// File: rtl/uart_cfg_rx.sv
// uart_cfg_rx: UART receiver and command-frame parser loading DDS frequency words and PWM duty registers.
// Ports:
//   clk, rst_n (async active-low)      system clock and reset
//   uart_rxd                            UART RX line, idle high, asynchronous
//   freq_word_1/2 [FW_W-1:0]            DDS frequency words
//   duty_ref_1/duty_dc_1/duty_ref_2/duty_dc_2 [15:0]  PWM thresholds
//   cfg_update                          one-cycle pulse on register write
//   frame_err                           one-cycle pulse on rejected frame
//   err_cnt [7:0]                       saturating rejected-frame counter
// Frame: A5, ADDR, D3, D2, D1, D0, CSUM with CSUM = sum(ADDR..D0) mod 256.
// Optional: define UART_CFG_PARITY_EN for one even-parity bit between D7 and stop.
module uart_cfg_rx #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BUAD_RATE    = 115200,
    parameter int FW_W         = 30,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            uart_rxd,
    output logic [FW_W-1:0] freq_word_1,
    output logic [FW_W-1:0] freq_word_2,
    output logic [15:0]     duty_ref_1,
    output logic [15:0]     duty_dc_1,
    output logic [15:0]     duty_ref_2,
    output logic [15:0]     duty_dc_2,
    output logic            cfg_update,
    output logic            frame_err,
    output logic [7:0]      err_cnt
);
    localparam int BIT_CNT = CLK_FREQ / BUAD_RATE;
    localparam int HALF    = BIT_CNT / 2;
    localparam int CW      = $clog2(BIT_CNT + 1);
    localparam int TO_MAX  = TIMEOUT_BITS * BIT_CNT;
    localparam int TW      = $clog2(TO_MAX + 1);
    localparam logic [FW_W-1:0] FW_RST = FW_W'(26_843_545);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {P_HDR, P_ADDR, P_DATA, P_CSUM} p_state_t;

    rx_state_t       rx_q, rx_d;
    p_state_t        p_q, p_d;
    logic [1:0]      sync_q, sync_d;
    logic            prev_q, prev_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sr_q, sr_d;
    logic            vld_q, vld_d;
    logic            berr_q, berr_d;
    logic [7:0]      addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic [7:0]      sum_q, sum_d;
    logic [1:0]      dcnt_q, dcnt_d;
    logic [TW-1:0]   to_q, to_d;
    logic [FW_W-1:0] fw1_q, fw1_d, fw2_q, fw2_d;
    logic [15:0]     dr1_q, dr1_d, dd1_q, dd1_d, dr2_q, dr2_d, dd2_q, dd2_d;
    logic            upd_q, upd_d, fe_q, fe_d;
    logic [7:0]      ecnt_q, ecnt_d;
    logic            rxs, rej;
`ifdef UART_CFG_PARITY_EN
    logic            par_q, par_d;
`endif

    assign rxs = sync_q[1];

    // Byte receiver: all samples are timed from the detected falling edge of the start bit.
    always_comb begin
        sync_d = {sync_q[0], uart_rxd};
        prev_d = rxs;
        rx_d   = rx_q;
        cnt_d  = cnt_q + 1'b1;
        bit_d  = bit_q;
        sr_d   = sr_q;
        vld_d  = 1'b0;
        berr_d = 1'b0;
`ifdef UART_CFG_PARITY_EN
        par_d  = par_q;
`endif
        case (rx_q)
            RX_IDLE: begin
                cnt_d = '0;
                rx_d  = (prev_q && !rxs) ? RX_START : RX_IDLE;
            end
            RX_START: if (cnt_q == CW'(HALF - 1)) begin
                cnt_d = '0;
                bit_d = '0;
                rx_d  = rxs ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == CW'(BIT_CNT - 1)) begin
                cnt_d = '0;
                sr_d  = {rxs, sr_q[7:1]};
                bit_d = bit_q + 1'b1;
`ifdef UART_CFG_PARITY_EN
                if (bit_q == 3'd7) rx_d = RX_PARITY;
`else
                if (bit_q == 3'd7) rx_d = RX_STOP;
`endif
            end
`ifdef UART_CFG_PARITY_EN
            RX_PARITY: if (cnt_q == CW'(BIT_CNT - 1)) begin
                cnt_d = '0;
                par_d = rxs ^ (^sr_q);
                rx_d  = RX_STOP;
            end
            RX_STOP: if (cnt_q == CW'(BIT_CNT - 1)) begin
                rx_d   = RX_IDLE;
                vld_d  = rxs && !par_q;
                berr_d = !(rxs && !par_q);
            end
`else
            RX_STOP: if (cnt_q == CW'(BIT_CNT - 1)) begin
                rx_d   = RX_IDLE;
                vld_d  = rxs;
                berr_d = !rxs;
            end
`endif
            default: rx_d = RX_IDLE;
        endcase
    end

    // Frame parser; a bad address is rejected as soon as the ADDR byte arrives.
    always_comb begin
        p_d    = p_q;
        addr_d = addr_q;
        data_d = data_q;
        sum_d  = sum_q;
        dcnt_d = dcnt_q;
        to_d   = (p_q == P_HDR || vld_q) ? '0 : to_q + 1'b1;
        fw1_d  = fw1_q;
        fw2_d  = fw2_q;
        dr1_d  = dr1_q;
        dd1_d  = dd1_q;
        dr2_d  = dr2_q;
        dd2_d  = dd2_q;
        upd_d  = 1'b0;
        fe_d   = 1'b0;
        ecnt_d = ecnt_q;
        rej    = p_q != P_HDR && (berr_q || (!vld_q && to_q == TW'(TO_MAX)));
        if (vld_q) begin
            case (p_q)
                P_HDR:  p_d = (sr_q == 8'hA5) ? P_ADDR : P_HDR;
                P_ADDR: begin
                    rej    = sr_q > 8'h05;
                    addr_d = sr_q;
                    sum_d  = sr_q;
                    dcnt_d = '0;
                    p_d    = P_DATA;
                end
                P_DATA: begin
                    data_d = {data_q[23:0], sr_q};
                    sum_d  = sum_q + sr_q;
                    dcnt_d = dcnt_q + 1'b1;
                    p_d    = (dcnt_q == 2'd3) ? P_CSUM : P_DATA;
                end
                P_CSUM: begin
                    rej   = sr_q != sum_q;
                    upd_d = sr_q == sum_q;
                    p_d   = P_HDR;
                end
                default: p_d = P_HDR;
            endcase
        end
        if (upd_d) begin
            fw1_d = (addr_q == 8'h00) ? data_q[FW_W-1:0] : fw1_q;
            fw2_d = (addr_q == 8'h01) ? data_q[FW_W-1:0] : fw2_q;
            dr1_d = (addr_q == 8'h02) ? data_q[15:0] : dr1_q;
            dd1_d = (addr_q == 8'h03) ? data_q[15:0] : dd1_q;
            dr2_d = (addr_q == 8'h04) ? data_q[15:0] : dr2_q;
            dd2_d = (addr_q == 8'h05) ? data_q[15:0] : dd2_q;
        end
        if (rej) begin
            fe_d   = 1'b1;
            ecnt_d = (ecnt_q == 8'hFF) ? ecnt_q : ecnt_q + 8'd1;
            p_d    = P_HDR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
            rx_q   <= RX_IDLE;
            cnt_q  <= '0;
            bit_q  <= '0;
            sr_q   <= '0;
            vld_q  <= 1'b0;
            berr_q <= 1'b0;
`ifdef UART_CFG_PARITY_EN
            par_q  <= 1'b0;
`endif
            p_q    <= P_HDR;
            addr_q <= '0;
            data_q <= '0;
            sum_q  <= '0;
            dcnt_q <= '0;
            to_q   <= '0;
            fw1_q  <= FW_RST;
            fw2_q  <= FW_RST;
            dr1_q  <= 16'd5000;
            dd1_q  <= 16'd10000;
            dr2_q  <= 16'hFFFF;
            dd2_q  <= 16'hFFFF;
            upd_q  <= 1'b0;
            fe_q   <= 1'b0;
            ecnt_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rx_q   <= rx_d;
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            sr_q   <= sr_d;
            vld_q  <= vld_d;
            berr_q <= berr_d;
`ifdef UART_CFG_PARITY_EN
            par_q  <= par_d;
`endif
            p_q    <= p_d;
            addr_q <= addr_d;
            data_q <= data_d;
            sum_q  <= sum_d;
            dcnt_q <= dcnt_d;
            to_q   <= to_d;
            fw1_q  <= fw1_d;
            fw2_q  <= fw2_d;
            dr1_q  <= dr1_d;
            dd1_q  <= dd1_d;
            dr2_q  <= dr2_d;
            dd2_q  <= dd2_d;
            upd_q  <= upd_d;
            fe_q   <= fe_d;
            ecnt_q <= ecnt_d;
        end
    end

    assign freq_word_1 = fw1_q;
    assign freq_word_2 = fw2_q;
    assign duty_ref_1  = dr1_q;
    assign duty_dc_1   = dd1_q;
    assign duty_ref_2  = dr2_q;
    assign duty_dc_2   = dd2_q;
    assign cfg_update  = upd_q;
    assign frame_err   = fe_q;
    assign err_cnt     = ecnt_q;
endmodule

// File: doc/uart_cfg_rx.md
Name: uart_cfg_rx

Overview:
- UART receiver and command-frame parser that loads the DDS frequency words and PWM duty-cycle registers from the MCU.
- Replaces the hard-coded register initialisers in the DAC top level.
- Sits directly upstream of the DDS cores and the DAC_REF/DAC_DC PWM generators.
- Runs in the 50 MHz system clock domain. Its register outputs are treated as quasi-static by the consumers.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BUAD_RATE, 115200, UART baud rate.
- FW_W, 30, frequency-word width.
- TIMEOUT_BITS, 20, maximum idle gap between bytes inside a frame, in bit periods.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- uart_rxd  in  1  UART RX line, idle high, asynchronous to clk
- freq_word_1  out  FW_W  DDS channel 1 frequency word
- freq_word_2  out  FW_W  DDS channel 2 frequency word
- duty_ref_1  out  16  DAC_REF_1 PWM threshold
- duty_dc_1  out  16  DAC_DC_1 PWM threshold
- duty_ref_2  out  16  DAC_REF_2 PWM threshold
- duty_dc_2  out  16  DAC_DC_2 PWM threshold
- cfg_update  out  1  one-cycle pulse when a register is written
- frame_err  out  1  one-cycle pulse when a frame is rejected
- err_cnt  out  8  saturating rejected-frame counter

Behaviour:
- Reset: one clock; reset is asynchronous, active-low (rst_n).
- Reset values:
  - freq_word_1 = freq_word_2 = 26_843_545.
  - duty_ref_1 = 5000, duty_dc_1 = 10000.
  - duty_ref_2 = duty_dc_2 = 65535.
  - cfg_update = 0, frame_err = 0, err_cnt = 0.
  - All internal state returns to IDLE.
- RX front end:
  - 2-FF synchronizer on uart_rxd, reset value 1.
  - BIT_CNT = CLK_FREQ/BUAD_RATE, integer truncated (434 at defaults). HALF = BIT_CNT/2 (217).
- Byte receiver states: RX_IDLE -> RX_START -> RX_DATA -> RX_STOP.
  - RX_IDLE: a falling edge on the synced line enters RX_START.
  - RX_START: sample at HALF. If the line is high, treat as a glitch and return to RX_IDLE.
  - RX_DATA: 8 bits, LSB first, each sampled BIT_CNT after the previous sample.
  - RX_STOP: stop bit sampled at mid-bit.
  - Stop = 1: byte valid pulses for one cycle, on the cycle after the stop sample.
  - Stop = 0: framing error; the byte is dropped and the parser aborts.
- Frame format: 0xA5, ADDR, D3, D2, D1, D0 (big-endian), CSUM.
  - CSUM = (ADDR + D3 + D2 + D1 + D0) mod 256.
- Parser states: P_HDR -> P_ADDR -> P_DATA (4 bytes) -> P_CSUM.
  - In P_HDR, any byte other than 0xA5 is ignored silently (no error).
- Commit, on the cycle after the CSUM byte-valid pulse:
  - Addresses: 0x00 freq_word_1, 0x01 freq_word_2, 0x02 duty_ref_1, 0x03 duty_dc_1, 0x04 duty_ref_2, 0x05 duty_dc_2.
  - freq words take data[FW_W-1:0]. Duty registers take data[15:0]. Upper bits are discarded.
  - cfg_update pulses in the same cycle as the write.
- Rejection: checksum mismatch, ADDR > 0x05, a stop-bit error in P_ADDR..P_CSUM, or the inter-byte timeout.
  - frame_err pulses once.
  - err_cnt increments, saturating at 255.
  - No register changes.
  - Parser returns to P_HDR.
- Timeout: the counter runs only while the parser is outside P_HDR. It is cleared at each byte-valid pulse. On reaching TIMEOUT_BITS*BIT_CNT cycles it rejects the frame.
- Simultaneous events: cfg_update and frame_err are never asserted together. A stop error in P_HDR produces no frame_err.
- Reset mid-frame: the partial frame is discarded and all registers return to their reset values.
- Frames sent back-to-back with no gap are all accepted.

Optional Feature:
- Macro: UART_CFG_PARITY_EN.
- Defined:
  - One even-parity bit is received after D7 and before stop (state RX_PARITY).
  - A parity mismatch is treated like a stop-bit error: the byte is dropped, and if the parser is in P_ADDR..P_CSUM it rejects the frame.
- Undefined: 8N1 framing, no parity state.

Test Plan:
- Send A5 00 01 00 00 00 01 at 115200 -> freq_word_1 = 16_777_216 one cycle after the CSUM byte is valid. cfg_update pulses once. err_cnt = 0.
- Send A5 02 00 00 0F A0 B1 -> duty_ref_1 = 4000. Then send A5 02 00 00 0F A0 B2 -> frame_err pulses, duty_ref_1 stays 4000, err_cnt = 1.
- Send A5 07 00 00 00 00 07 -> frame_err, no register changes. Then send 0x55 0xA5 03 00 00 00 64 67 -> duty_dc_1 = 100; the leading 0x55 causes no error.
- Send A5 04 00 00, idle 25 bit periods, then 00 10 14 -> timeout frame_err, err_cnt increments, duty_ref_2 stays 65535. The trailing bytes do not form a valid frame.
- Assert rst_n low after A5 01 00 00 -> all outputs at reset values. A subsequent complete valid frame is accepted.
- Push 300 bad-checksum frames -> err_cnt saturates at 255. Apply a 100-cycle low glitch on uart_rxd -> no byte is received.
